// File: rtl/ex_mem_pkg.sv
// Shared encodings for the EX-stage memory request agent.
package ex_mem_pkg;

   // Access size encodings as carried on in_size / size.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // Counter width for in-flight / cancelled request tracking (MAX_OUTST <= 4).
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_REQ         = 2'd1,
      ST_DONE        = 2'd2,
      ST_CANCEL_WAIT = 2'd3
   } state_t;

   // Byte-enable pattern for an access of the given size at offset 0.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         SZ_B:    size_mask = 8'h01;
         SZ_H:    size_mask = 8'h03;
         SZ_W:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/ex_mem_align.sv
// Alignment check, byte strobes and lane-replicated store data for one access.
module ex_mem_align
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]          size,
   input  logic [2:0]          addr_lo,
   input  logic [DATA_W-1:0]   wdata,
   output logic                ale,
   output logic [DATA_W/8-1:0] strb,
   output logic [DATA_W-1:0]   wdata_rep
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   // A dword can never be issued on a 32-bit bus, so it is treated as misaligned.
   always_comb begin
      ale = 1'b0;
      case (size)
         SZ_H:    ale = addr_lo[0];
         SZ_W:    ale = (addr_lo[1:0] != 2'b00);
         SZ_D:    ale = (addr_lo != 3'b000) || (DATA_W == 32);
         default: ale = 1'b0;
      endcase
   end

   assign strb = NB'(size_mask(size)) << addr_lo[OFF_W-1:0];

   // Replicate the store source across all lanes so the slave picks any lane by strobe.
   always_comb begin
      wdata_rep = wdata;
      case (size)
         SZ_B:    wdata_rep = {NB{wdata[7:0]}};
         SZ_H:    wdata_rep = {(NB/2){wdata[15:0]}};
         SZ_W:    wdata_rep = {(NB/4){wdata[31:0]}};
         default: wdata_rep = wdata;
      endcase
   end

endmodule

// File: rtl/ex_mem_req_agent.sv
// EX-stage memory request agent: accepts one instruction, issues it on the
// req/addr_ok/data_ok data bus, and hands it to ME. Flushed requests that are
// already on the bus are counted so their responses can be marked as discard.
module ex_mem_req_agent
   import ex_mem_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MAX_OUTST = 2,
   parameter int DEST_W    = 5
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_mem_en,
   input  logic                         in_mem_wr,
   input  logic [1:0]                   in_size,
   input  logic                         in_signed,
   input  logic [ADDR_W-1:0]            in_addr,
   input  logic [DATA_W-1:0]            in_wdata,
   input  logic [DEST_W-1:0]            in_dest,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_ale,
   output logic                         out_mem_en,
   output logic                         out_wr,
   output logic [1:0]                   out_size,
   output logic                         out_signed,
   output logic [DEST_W-1:0]            out_dest,
   output logic [$clog2(DATA_W/8)-1:0]  out_offset,
   input  logic                         flush,
   output logic                         req,
   output logic                         wr,
   output logic [1:0]                   size,
   output logic [DATA_W/8-1:0]          wstrb,
   output logic [ADDR_W-1:0]            addr,
   output logic [DATA_W-1:0]            wdata,
   input  logic                         addr_ok,
   input  logic                         data_ok,
   output logic                         data_ok_discard
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   state_t               state_q, state_d;
   logic                 mem_en_q, wr_q, signed_q, ale_q;
   logic [1:0]           size_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DEST_W-1:0]    dest_q;
   logic [NB-1:0]        strb_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [CNT_W-1:0]     outst_cnt, cancel_cnt;

   logic                 in_ale;
   logic [NB-1:0]        in_strb;
   logic [DATA_W-1:0]    in_wrep;
   logic                 req_int, accept, bus_acc, to_req, issued_q;
   logic                 outst_inc, outst_dec, cancel_inc, cancel_dec;

   ex_mem_align #(.DATA_W(DATA_W)) u_align (
      .size      (in_size),
      .addr_lo   (in_addr[2:0]),
      .wdata     (in_wdata),
      .ale       (in_ale),
      .strb      (in_strb),
      .wdata_rep (in_wrep)
   );

   assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign to_req   = in_mem_en && !in_ale;
   assign bus_acc  = req_int && addr_ok;
   assign issued_q = mem_en_q && !ale_q;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next state; flush overrides everything except a request already on the bus.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = to_req ? ST_REQ : ST_DONE;
         end
         ST_REQ: begin
            if (flush) begin
               if (!req_int || bus_acc) state_d = ST_IDLE;
               else                     state_d = ST_CANCEL_WAIT;
            end else if (bus_acc) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (flush)          state_d = ST_IDLE;
            else if (accept)    state_d = to_req ? ST_REQ : ST_DONE;
            else if (out_ready) state_d = ST_IDLE;
         end
         ST_CANCEL_WAIT: begin
            if (bus_acc) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from registered state only, so req cannot glitch on inputs.
   always_comb begin
      out_valid = 1'b0;
      req_int   = 1'b0;
      case (state_q)
         ST_REQ:         req_int   = (outst_cnt < CNT_W'(MAX_OUTST));
         ST_DONE:        out_valid = 1'b1;
         ST_CANCEL_WAIT: req_int   = 1'b1;
         default: ;
      endcase
   end

   // Capture the accepted instruction; bus fields stay stable while req waits.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_en_q <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         dest_q   <= '0;
         ale_q    <= 1'b0;
         strb_q   <= '0;
         wdata_q  <= '0;
      end else if (accept) begin
         mem_en_q <= in_mem_en;
         wr_q     <= in_mem_wr;
         size_q   <= in_size;
         signed_q <= in_signed;
         addr_q   <= in_addr;
         dest_q   <= in_dest;
         ale_q    <= in_ale;
         strb_q   <= in_mem_wr ? in_strb : '0;
         wdata_q  <= in_wrep;
      end
   end

   assign outst_inc  = bus_acc;
   assign outst_dec  = data_ok && (outst_cnt != '0);
   assign cancel_inc = (flush && (((state_q == ST_REQ) && bus_acc) ||
                                  ((state_q == ST_DONE) && issued_q))) ||
                       ((state_q == ST_CANCEL_WAIT) && bus_acc);
   assign cancel_dec = data_ok && (cancel_cnt != '0);

   // In-flight and cancelled request counters; responses return in order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outst_cnt  <= '0;
         cancel_cnt <= '0;
      end else begin
         case ({outst_inc, outst_dec})
            2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
            2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
            default: ;
         endcase
         case ({cancel_inc, cancel_dec})
            2'b10:   cancel_cnt <= cancel_cnt + CNT_W'(1);
            2'b01:   cancel_cnt <= cancel_cnt - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign data_ok_discard = cancel_dec;

   assign req        = req_int;
   assign wr         = wr_q;
   assign size       = size_q;
   assign addr       = addr_q;
   assign wstrb      = strb_q;
   assign wdata      = wdata_q;
   assign out_ale    = ale_q;
   assign out_mem_en = mem_en_q;
   assign out_wr     = wr_q;
   assign out_size   = size_q;
   assign out_signed = signed_q;
   assign out_dest   = dest_q;
   assign out_offset = addr_q[OFF_W-1:0];

   // A response with nothing in flight means the slave broke the protocol.
   a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
      !(data_ok && (outst_cnt == '0)));

endmodule

// File: doc/ex_mem_req_agent.md
Name: ex_mem_req_agent

Overview:
- EX-stage memory request agent: takes one instruction per handshake from ID/EX and computes alignment, byte strobes and replicated write data.
- Issues requests on an SRAM-like data bus (req/addr_ok/data_ok) with up to MAX_OUTST requests in flight, then passes the instruction to ME.
- Replaces the always-ready, single-cycle data_sram path. Adds DATA_W generalisation (32/64), ALE detection and flush cancellation of in-flight requests.

Parameters:
- DATA_W, 32, bus data width; 32 or 64.
- ADDR_W, 32, address width.
- MAX_OUTST, 2, maximum accepted-but-unanswered requests (1..4).
- DEST_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  agent can accept.
- in_mem_en  in  1  instruction accesses memory.
- in_mem_wr  in  1  store (1) / load (0).
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- in_signed  in  1  load sign-extend flag (passed through).
- in_addr  in  ADDR_W  effective address.
- in_wdata  in  DATA_W  store source (low bits used).
- in_dest  in  DEST_W  destination register.
- out_valid  out  1  to ME valid.
- out_ready  in  1  ME allow-in.
- out_ale  out  1  misaligned access; no bus request was made.
- out_mem_en / out_wr / out_size / out_signed / out_dest  out  1/1/2/1/DEST_W  registered copies.
- out_offset  out  log2(DATA_W/8)  addr low bits, for ME load extraction.
- flush  in  1  exception/ertn flush.
- req  out  1  bus request.
- wr  out  1  bus write.
- size  out  2  bus size.
- wstrb  out  DATA_W/8  byte enables (0 for loads).
- addr  out  ADDR_W  bus address.
- wdata  out  DATA_W  bus write data.
- addr_ok  in  1  request accepted this cycle (valid only with req).
- data_ok  in  1  response returned (in order).
- data_ok_discard  out  1  this data_ok belongs to a cancelled request; ME ignores it.

Behaviour:
- Reset (resetn low, async): state IDLE. All outputs 0. outst_cnt=0, cancel_cnt=0. Held fields cleared.
- States: IDLE, REQ, DONE, CANCEL_WAIT.
- in_ready = !flush & (state==IDLE | (state==DONE & out_ready)). Accept = in_valid & in_ready; fields registered.
- On accept:
  - ALE = half&addr[0] | word&addr[1:0]!=0 | dword&addr[2:0]!=0 | dword&DATA_W==32.
  - No-mem or ALE -> DONE next cycle (out_valid at N+1).
  - Otherwise -> REQ.
- REQ: req = (outst_cnt < MAX_OUTST), registered from state/count.
  - req & addr_ok -> outst_cnt++, DONE.
  - Earliest out_valid for a mem op is N+2.
  - Once req is high it stays high with stable addr/wr/size/wstrb/wdata until addr_ok.
- DONE: out_valid=1; leaves on out_ready (to IDLE, or reload on same-cycle accept).
- Bus data:
  - wstrb = size mask shifted by offset: byte 1, half 2'b11, word 4'hF, dword 8'hFF.
  - wdata replicates: byte {N{b}}, half {N{h}}, word {N{w}}, dword as-is.
- data_ok: outst_cnt--. If cancel_cnt>0: cancel_cnt-- and data_ok_discard=1 (combinational, same cycle).
  - addr_ok and data_ok in the same cycle: count unchanged.
- Flush (highest priority):
  - IDLE: no effect.
  - REQ with req low: -> IDLE, nothing issued.
  - REQ with req high and no addr_ok: -> CANCEL_WAIT; req held until addr_ok, then outst_cnt++, cancel_cnt++, -> IDLE.
  - REQ with addr_ok in the flush cycle: outst_cnt++, cancel_cnt++, -> IDLE.
  - DONE holding an issued mem op: cancel_cnt++, -> IDLE.
  - DONE holding a non-issued op: -> IDLE.
  - out_valid falls the cycle after flush.
  - in_ready=0 in CANCEL_WAIT.
- Invariants: cancel_cnt <= outst_cnt <= MAX_OUTST. data_ok with outst_cnt==0 is a bus protocol error (assertion).

Decomposition:
- Package ex_mem_pkg: size encodings (SZ_B/H/W/D), state encoding, helper function for strobe masks.
- Sub-module ex_mem_align (combinational): ALE, wstrb, replicated wdata from size/addr/wdata, parametrised by DATA_W.

Test Plan:
- Word store, DATA_W=32, addr 0x1000_0004, wdata 0x1122_3344, addr_ok at first req cycle -> req high N+1, wstrb 4'hF, out_valid N+2, out_ale=0.
- Byte store addr 0x...3, wdata 0xAB -> wstrb 4'b1000, wdata 0xABAB_ABAB.
- Half load addr 0x...1 -> out_ale=1, req never asserted, out_valid at N+1.
- MAX_OUTST=2, two loads accepted, data_ok withheld; third load -> req stays low in REQ.
  - data_ok -> req rises the next cycle.
- Flush while req high and addr_ok delayed 3 cycles -> req held 3 cycles, in_ready=0.
  - After addr_ok, next data_ok has data_ok_discard=1, cancel_cnt back to 0.
- DATA_W=64 dword store addr 0x8 -> wstrb 8'hFF.
  - DATA_W=32 dword -> out_ale=1.
  - resetn pulsed low mid-REQ -> req drops asynchronously, counters 0.
